// File: rtl/image_window_display.sv
// Pixel-fetch and compositing stage: maps the scan position onto an image window,
// fetches pixels from the image RAM and drives registered RGB with aligned side-band.
module image_window_display #(
    parameter int                PIX_W      = 24,
    parameter int                XY_W       = 10,
    parameter int                WIN_X0     = 120,
    parameter int                WIN_Y0     = 40,
    parameter int                IMG_W      = 400,
    parameter int                IMG_H      = 400,
    parameter int                SCALE_LOG2 = 0,
    parameter int                ADDR_W     = 18,
    parameter int                RAM_LAT    = 1,
    parameter logic [PIX_W-1:0]  BG_COLOR   = 24'h000000,
    parameter int                CHK_LOG2   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XY_W-1:0]   x,
    input  logic [XY_W-1:0]   y,
    input  logic              active,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [PIX_W-1:0]  data_ram,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_done
);

    typedef enum logic [1:0] {IDLE, ARM, SHOW} state_t;

    localparam logic [31:0] WIN_W = 32'(IMG_W) << SCALE_LOG2;
    localparam logic [31:0] WIN_H = 32'(IMG_H) << SCALE_LOG2;
    localparam int          SB_W  = 6;

    state_t            state_reg;
    logic [1:0]        mode_q_reg;
    logic [PIX_W-1:0]  rgb_reg;
    logic [SB_W-1:0]   sb_reg [0:RAM_LAT];

    logic [XY_W:0]     dx;
    logic [XY_W:0]     dy;
    logic              frame_start;
    logic              show_now;
    logic              in_win;
    logic              is_last;
    logic              chk_bit;
    logic [1:0]        mode_now;
    logic [SB_W-1:0]   sb_now;
    logic [SB_W-1:0]   sb_out;
    logic [PIX_W-1:0]  pix_next;

    // Unsigned wrap makes coordinates left of / above the window compare as large.
    assign dx          = {1'b0, x} - (XY_W+1)'(WIN_X0);
    assign dy          = {1'b0, y} - (XY_W+1)'(WIN_Y0);
    assign frame_start = (x == '0) && (y == '0);
    assign in_win      = active && (32'(dx) < WIN_W) && (32'(dy) < WIN_H);
    assign is_last     = (32'(dx) == WIN_W - 32'd1) && (32'(dy) == WIN_H - 32'd1);
    assign chk_bit     = dx[CHK_LOG2] ^ dy[CHK_LOG2];

    // State transitions at frame start already govern the frame-start pixel itself.
    assign show_now = ((state_reg == SHOW) && !(frame_start && !start)) ||
                      ((state_reg == ARM) && frame_start && start);
    assign mode_now = (frame_start && show_now) ? mode : mode_q_reg;

    assign sb_now = {show_now, active, in_win, mode_now, chk_bit};
    assign sb_out = sb_reg[RAM_LAT];

    always_comb begin
        pix_next = '0;
        if (sb_out[5] && sb_out[4]) begin
            if (!sb_out[3]) begin
                pix_next = BG_COLOR;
            end else begin
                case (sb_out[2:1])
                    2'd0:    pix_next = data_ram;
                    2'd1:    pix_next = 24'h00FF00;
                    2'd2:    pix_next = sb_out[0] ? 24'hFFFFFF : 24'h000000;
                    default: pix_next = BG_COLOR;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            mode_q_reg <= 2'd0;
            ram_addr   <= '0;
            ram_rd_en  <= 1'b0;
            frame_done <= 1'b0;
            rgb_reg    <= '0;
            for (int i = 0; i <= RAM_LAT; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: if (start) state_reg <= ARM;
                ARM: begin
                    if (frame_start && start) state_reg <= SHOW;
                    else if (!start)          state_reg <= IDLE;
                end
                SHOW: if (frame_start && !start) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if (frame_start && show_now) begin
                mode_q_reg <= mode;
            end

            ram_addr   <= ADDR_W'(((32'(dy) >> SCALE_LOG2) * 32'(IMG_W)) + (32'(dx) >> SCALE_LOG2));
            ram_rd_en  <= show_now && in_win && (mode_now == 2'd0);
            frame_done <= show_now && is_last;

            // Side-band rides alongside the RAM read so every mode has the same latency.
            sb_reg[0] <= sb_now;
            for (int i = 1; i <= RAM_LAT; i++) begin
                sb_reg[i] <= sb_reg[i-1];
            end
            rgb_reg <= pix_next;
        end
    end

    assign red   = rgb_reg[23:16];
    assign green = rgb_reg[15:8];
    assign blue  = rgb_reg[7:0];

endmodule

// File: tb/tb_image_window_display.sv
// Scoreboard bench: stimulus pushes expected address/strobe/RGB, a negedge monitor compares.
module tb_image_window_display;

    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_SHOW = 2;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  x = 10'd1;
    logic [9:0]  y = 10'd1;
    logic        active = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        ram_const = 1'b0;

    logic [17:0] ram_addr_a, ram_addr_b;
    logic        ram_rd_en_a, ram_rd_en_b;
    logic [23:0] data_ram_a;
    logic [23:0] data_ram_b;
    logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        frame_done_a, frame_done_b;

    image_window_display #(.BG_COLOR(BG)) dut_a (
        .clk(clk), .reset(reset), .x(x), .y(y), .active(active), .start(start), .mode(mode),
        .ram_addr(ram_addr_a), .ram_rd_en(ram_rd_en_a), .data_ram(data_ram_a),
        .red(red_a), .green(green_a), .blue(blue_a), .frame_done(frame_done_a)
    );

    image_window_display #(.IMG_W(200), .IMG_H(200), .SCALE_LOG2(1), .BG_COLOR(BG)) dut_b (
        .clk(clk), .reset(reset), .x(x), .y(y), .active(active), .start(start), .mode(mode),
        .ram_addr(ram_addr_b), .ram_rd_en(ram_rd_en_b), .data_ram(data_ram_b),
        .red(red_b), .green(green_b), .blue(blue_b), .frame_done(frame_done_b)
    );

    initial forever #5 clk = ~clk;

    // Image RAM model with one cycle of read latency.
    always @(posedge clk) begin
        data_ram_a <= ram_const ? 24'hA1B2C3 : {6'h2A, ram_addr_a};
    end
    assign data_ram_b = 24'h0;

    typedef struct { int due; int id; logic rd; logic [17:0] addr; logic fd; } aexp_t;
    typedef struct { int due; int id; logic [23:0] rgb; } rexp_t;
    aexp_t qa[$];
    aexp_t qb[$];
    rexp_t qr[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int vid = 0;
    int m_state = S_IDLE;
    logic [1:0] m_mode = 2'd0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic cmp(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h exp %h", nm, id, got, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    initial forever begin
        aexp_t a;
        rexp_t r;
        @(negedge clk);
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            a = qa.pop_front();
            cmp("rd_en_a", a.id, 32'(ram_rd_en_a), 32'(a.rd));
            if (a.rd) cmp("addr_a", a.id, 32'(ram_addr_a), 32'(a.addr));
            cmp("frame_done_a", a.id, 32'(frame_done_a), 32'(a.fd));
        end
        while (qb.size() > 0 && qb[0].due <= cyc) begin
            a = qb.pop_front();
            cmp("rd_en_b", a.id, 32'(ram_rd_en_b), 32'(a.rd));
            if (a.rd) cmp("addr_b", a.id, 32'(ram_addr_b), 32'(a.addr));
        end
        while (qr.size() > 0 && qr[0].due <= cyc) begin
            r = qr.pop_front();
            cmp("rgb_a", r.id, {8'h0, red_a, green_a, blue_a}, {8'h0, r.rgb});
            $display("[TB] txn %0d rgb=%h", r.id, {red_a, green_a, blue_a});
        end
    end

    // Drive one pixel for one cycle; ea/eb are hand-computed addresses, -1 = derive from x,y.
    task automatic step(input int px, input int py, input logic act, input int ea, input int eb);
        int nst, dx, dy, addr_a, addr_b;
        logic fs, show, inw, rd, last;
        logic [23:0] dat, pix;
        fs  = (px == 0) && (py == 0);
        nst = m_state;
        case (m_state)
            S_IDLE: if (start) nst = S_ARM;
            S_ARM:  if (fs && start) nst = S_SHOW; else if (!start) nst = S_IDLE;
            default: if (fs && !start) nst = S_IDLE;
        endcase
        show = fs ? (nst == S_SHOW) : (m_state == S_SHOW);
        if (fs && nst == S_SHOW) m_mode = mode;
        m_state = nst;
        dx  = px - 120;
        dy  = py - 40;
        inw = act && dx >= 0 && dx < 400 && dy >= 0 && dy < 400;
        addr_a = (ea >= 0) ? ea : dy * 400 + dx;
        addr_b = (eb >= 0) ? eb : (dy / 2) * 200 + dx / 2;
        rd   = show && inw && (m_mode == 2'd0);
        last = show && dx == 399 && dy == 399;
        dat  = ram_const ? 24'hA1B2C3 : {6'h2A, 18'(addr_a)};
        if (!show || !act)  pix = 24'h0;
        else if (!inw)      pix = BG;
        else begin
            case (m_mode)
                2'd0:    pix = dat;
                2'd1:    pix = 24'h00FF00;
                2'd2:    pix = (((dx ^ dy) >> 4) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                default: pix = BG;
            endcase
        end
        qa.push_back('{cyc + 1, vid, rd, 18'(addr_a), last});
        qb.push_back('{cyc + 1, vid, rd, 18'(addr_b), last});
        qr.push_back('{cyc + 3, vid, pix});
        vid++;
        x = 10'(px);
        y = 10'(py);
        active = act;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        cmp("rst_rgb_a", 0, {8'h0, red_a, green_a, blue_a}, 32'h0);
        cmp("rst_ctl_a", 0, {12'h0, ram_addr_a, ram_rd_en_a, frame_done_a}, 32'h0);
        cmp("rst_rgb_b", 0, {8'h0, red_b, green_b, blue_b}, 32'h0);
        reset = 1'b1;

        // IDLE with start low, including a frame start: stays black.
        step(300, 300, 1, -1, -1);
        step(0, 0, 0, -1, -1);
        step(200, 200, 1, -1, -1);

        // Arm and enter SHOW at frame start, mode 0.
        start = 1'b1;
        step(10, 10, 0, -1, -1);
        step(300, 300, 1, -1, -1);
        step(0, 0, 0, -1, -1);
        step(120, 40, 1, 0, 0);
        step(519, 40, 1, 399, 199);
        step(120, 41, 1, 400, 0);
        step(121, 41, 1, 401, 0);
        step(122, 40, 1, 2, 1);
        step(120, 42, 1, 800, 200);
        step(519, 439, 1, 159999, 39999);
        step(119, 40, 1, -1, -1);
        step(520, 40, 1, -1, -1);
        step(300, 39, 1, -1, -1);
        step(300, 440, 1, -1, -1);
        step(300, 200, 0, -1, -1);
        step(5, 5, 1, -1, -1);

        // Constant RAM word flows straight to RGB.
        ram_const = 1'b1;
        step(5, 5, 0, -1, -1);
        step(200, 100, 1, -1, -1);
        step(5, 5, 0, -1, -1);
        step(5, 5, 0, -1, -1);
        ram_const = 1'b0;

        // Mid-frame switch to checkerboard only lands at the next frame start.
        mode = 2'd2;
        step(120, 40, 1, -1, -1);
        step(0, 0, 0, -1, -1);
        step(120, 40, 1, -1, -1);
        step(136, 40, 1, -1, -1);
        step(120, 56, 1, -1, -1);
        step(136, 56, 1, -1, -1);
        step(519, 439, 1, -1, -1);

        mode = 2'd1;
        step(0, 0, 0, -1, -1);
        step(200, 200, 1, -1, -1);
        step(50, 50, 1, -1, -1);
        mode = 2'd3;
        step(0, 0, 0, -1, -1);
        step(200, 200, 1, -1, -1);
        mode = 2'd0;
        step(0, 0, 0, -1, -1);
        step(200, 200, 1, -1, -1);

        // Stop at frame start, then raise start mid-frame.
        start = 1'b0;
        step(300, 300, 1, -1, -1);
        step(0, 0, 0, -1, -1);
        step(200, 100, 1, -1, -1);
        start = 1'b1;
        step(200, 200, 1, -1, -1);
        step(250, 300, 1, -1, -1);
        step(0, 0, 0, -1, -1);
        step(200, 200, 1, -1, -1);
        step(201, 200, 1, -1, -1);
        step(202, 200, 1, -1, -1);

        // Asynchronous reset mid-SHOW clears outputs before any clock edge.
        reset = 1'b0;
        #1;
        cmp("async_rgb_a", 1, {8'h0, red_a, green_a, blue_a}, 32'h0);
        cmp("async_ctl_a", 1, {12'h0, ram_addr_a, ram_rd_en_a, frame_done_a}, 32'h0);
        cmp("async_rd_b", 1, {31'h0, ram_rd_en_b}, 32'h0);
        qa.delete();
        qb.delete();
        qr.delete();
        m_state = S_IDLE;
        m_mode  = 2'd0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(200, 200, 1, -1, -1);
        step(210, 210, 1, -1, -1);
        step(0, 0, 0, -1, -1);
        step(200, 200, 1, -1, -1);
        step(300, 300, 1, -1, -1);
        step(5, 5, 0, -1, -1);

        repeat (5) @(posedge clk);
        #2;
        cmp("drain", 2, 32'(qa.size() + qb.size() + qr.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_window_display.md
# image_window_display

Parametrised pixel-fetch and compositing stage between the VGA timing generator and the RGB DAC outputs. It maps the current scan position onto a configurable on-screen window and issues read addresses to the image RAM. It aligns the returned pixel with a delayed side-band pipeline and drives registered RGB. It also supports integer upscaling, built-in test patterns, a background colour and frame-synchronous start/stop, so mode changes never tear mid-frame.

## Interface
- PIX_W, 24: pixel word width, packed {R,G,B}, 8 bits each.
- XY_W, 10: width of x/y scan coordinates.
- WIN_X0, 120: screen column of the window's left edge.
- WIN_Y0, 40: screen row of the window's top edge.
- IMG_W, 400: stored image width in pixels.
- IMG_H, 400: stored image height in pixels.
- SCALE_LOG2, 0: upscale factor 2^SCALE_LOG2. On-screen window is (IMG_W<<S) x (IMG_H<<S).
- ADDR_W, 18: RAM address width. Must hold IMG_W*IMG_H-1.
- RAM_LAT, 1: image RAM read latency in cycles, ≥1.
- BG_COLOR, 24'h000000: colour shown outside the window while displaying.
- CHK_LOG2, 4: checkerboard square size 2^CHK_LOG2 screen pixels.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low. 0 = reset asserted.
- x  in  XY_W  current scan column.
- y  in  XY_W  current scan row.
- active  in  1  visible-area flag from the timing generator.
- start  in  1  display enable. Level-sensitive; acted on only at frame start.
- mode  in  2  0 image, 1 solid green window, 2 checkerboard window, 3 background only.
- ram_addr  out  ADDR_W  registered image RAM read address.
- ram_rd_en  out  1  registered read strobe.
- data_ram  in  PIX_W  RAM read data, valid RAM_LAT cycles after ram_addr.
- red  out  8  registered.
- green  out  8  registered.
- blue  out  8  registered.
- frame_done  out  1  one-cycle pulse after the last window pixel is fetched.

## Operation
- Frame start is defined as the cycle where x==0 and y==0 are sampled.
- FSM states:
  - IDLE: outputs black, ram_rd_en=0. Goes to ARM when start=1.
  - ARM: outputs black. Goes to SHOW at frame start if start=1; returns to IDLE if start=0.
  - SHOW: normal display. Goes to IDLE at frame start if start=0, otherwise stays.
- mode is latched into mode_q on every transition into SHOW and at every frame start while in SHOW. A mid-frame mode change is ignored until the next frame.
- In-window test: in_win = active && (x-WIN_X0) < (IMG_W<<S) && (y-WIN_Y0) < (IMG_H<<S). Subtractions are unsigned XY_W+1 bits, so coordinates left of or above the window fall outside.
- Address: ram_addr = ((y-WIN_Y0)>>S)*IMG_W + ((x-WIN_X0)>>S), truncated to ADDR_W. An incremental row-base/column counter is permitted if the results are identical. ram_rd_en = SHOW && in_win && mode_q==0.
- Pixel colour, by case:
  - active=0, or state ≠ SHOW: 0.
  - Outside the window: BG_COLOR.
  - Inside, mode_q 0: data_ram.
  - Inside, mode_q 1: 24'h00FF00.
  - Inside, mode_q 2: 24'hFFFFFF if bit CHK_LOG2 of (x-WIN_X0) XOR (y-WIN_Y0) is 1, else 0.
  - Inside, mode_q 3: BG_COLOR.
- Output mapping: red=pixel[23:16], green=pixel[15:8], blue=pixel[7:0].
- frame_done is registered high for one cycle when the sampled x,y are the window's bottom-right pixel in SHOW, in any mode.
- Reset while asserted: state IDLE, mode_q=0, ram_addr=0, ram_rd_en=0, red/green/blue=0, frame_done=0, all side-band pipeline stages cleared. Reset is effective immediately mid-frame.

## Timing
- Edge k samples x, y and active; ram_addr and ram_rd_en update on edge k.
- data_ram for that address is consumed at edge k+RAM_LAT.
- RGB is registered at edge k+RAM_LAT+1.
- Total x,y-to-RGB latency is RAM_LAT+1 cycles for every mode. Side-band signals (in_win, active, state gate, mode_q, pattern bit) are delayed through a RAM_LAT+1 stage shift register so non-image pixels stay aligned.
- frame_done has 1-cycle latency from sampling the bottom-right pixel.
- FSM transitions take effect for the pixel sampled at frame start. That pixel is already blanked by active=0 when the timing generator uses a standard porch.

## Test plan
- Defaults, mode 0, start=1, advance to SHOW:
  - (120,40) → ram_addr=0.
  - (519,40) → 399.
  - (120,41) → 400.
  - (519,439) → 159999, plus one frame_done pulse.
  - (119,40) and (520,40) → ram_rd_en=0.
- RAM_LAT=1, data_ram=24'hA1B2C3 held: in-window pixel → red=A1, green=B2, blue=C3 exactly 2 cycles after x,y. Out-of-window pixel with BG_COLOR=24'h102030 → 10/20/30.
- SCALE_LOG2=1, IMG 200x200:
  - (120,40) and (121,41) → addr 0.
  - (122,40) → 1.
  - (120,42) → 200.
  - (519,439) → 39999.
- start raised at y=200 → output stays black until the next frame start, then the image appears. mode 0→2 mid-frame → checkerboard only from the next frame. Checkerboard at (120,40) → 0; at (136,40) → FFFFFF.
- reset=0 asserted mid-SHOW → all outputs 0 within the same cycle, state IDLE. After release with start=1 → black until frame start, then display resumes.
- active=0 inside the window coordinates → RGB 0 and ram_rd_en=0.
